// File: rtl/vc_pkg.sv
// Shared types and defaults for the op_sequencer result-streaming path.
package vc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_CORE,
        LOAD,
        SEND,
        WAIT_TX,
        NEXT,
        DONE
    } seq_state_t;

    localparam int VEC_BYTES_DEF  = 2;
    localparam int SCAL_BYTES_DEF = 4;
    localparam int SCALAR_W       = 8 * SCAL_BYTES_DEF;

endpackage

// File: rtl/timeout_counter.sv
// Watchdog for the processing core: counts enabled cycles and flags the last one.
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Saturates at LAST so a stalled enable cannot wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/op_sequencer.sv
// Starts the processing core for each command and streams its result to the UART,
// byte by byte (LSB first), for either a single scalar or a DEPTH-element vector.
module op_sequencer
    import vc_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int VEC_BYTES      = VEC_BYTES_DEF,
    parameter int SCAL_BYTES     = SCAL_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_ready,
    input  logic                       out_mode,
    output logic                       core_start,
    input  logic                       core_done,
    output logic [$clog2(DEPTH)-1:0]   r_addr,
    output logic [1:0]                 byte_sel,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       timeout_err,
    output logic                       cmd_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [1:0]    VEC_LAST  = 2'(VEC_BYTES - 1);
    localparam logic [1:0]    SCAL_LAST = 2'(SCAL_BYTES - 1);

    seq_state_t      state_q;
    logic            mode_q;
    logic [AW-1:0]   r_addr_q;
    logic [1:0]      byte_sel_q;
    logic            core_start_q;
    logic            tx_start_q;
    logic            seq_done_q;
    logic            cmd_drop_q;
    logic            busy_q;
    logic            timeout_err_q;
    logic            first_q;
    logic [1:0]      rst_sync_q;
    logic            rst_int_n;
    logic            last_byte_ok;
    logic            expired;

    // Reset asserts asynchronously but releases two clocks later on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .clear   (state_q == START),
        .enable  (state_q == WAIT_CORE),
        .expired (expired)
    );

    assign last_byte_ok = byte_sel_q < (mode_q ? SCAL_LAST : VEC_LAST);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            r_addr_q      <= '0;
            byte_sel_q    <= '0;
            core_start_q  <= 1'b0;
            tx_start_q    <= 1'b0;
            seq_done_q    <= 1'b0;
            cmd_drop_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            seq_done_q   <= 1'b0;
            cmd_drop_q   <= cmd_ready && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (cmd_ready) begin
                        state_q       <= START;
                        mode_q        <= out_mode;
                        timeout_err_q <= 1'b0;
                        core_start_q  <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                START: state_q <= WAIT_CORE;
                WAIT_CORE: begin
                    if (core_done) begin
                        state_q    <= LOAD;
                        r_addr_q   <= '0;
                        byte_sel_q <= '0;
                    end else if (expired) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                // tx_start is decided one cycle early so it is high on the first SEND cycle.
                LOAD: begin
                    state_q    <= SEND;
                    tx_start_q <= !tx_busy;
                end
                SEND: begin
                    if (tx_start_q) begin
                        state_q <= WAIT_TX;
                        first_q <= 1'b1;
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                    end
                end
                WAIT_TX: begin
                    first_q <= 1'b0;
                    if (!first_q && !tx_busy) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_byte_ok) begin
                        byte_sel_q <= byte_sel_q + 2'd1;
                        state_q    <= SEND;
                        tx_start_q <= !tx_busy;
                    end else if (!mode_q && (r_addr_q != ADDR_LAST)) begin
                        byte_sel_q <= '0;
                        r_addr_q   <= r_addr_q + 1'b1;
                        state_q    <= LOAD;
                    end else begin
                        state_q    <= DONE;
                        seq_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_start  = core_start_q;
    assign r_addr      = r_addr_q;
    assign byte_sel    = byte_sel_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = timeout_err_q;
    assign cmd_drop    = cmd_drop_q;

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter DEPTH, default 1024: elements per vector result.
REQ-002 Parameter VEC_BYTES, default 2: UART bytes per vector element.
REQ-003 Parameter SCAL_BYTES, default 4: UART bytes per scalar result.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536: max cycles from core_start to core_done.
REQ-005 Port clk, input, 1: single clock. Every flop is on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port cmd_ready, input, 1: one-cycle pulse; a decoded command is valid.
REQ-008 Port out_mode, input, 1: 1 = scalar result, 0 = vector result. Sampled with cmd_ready.
REQ-009 Port core_start, output, 1: one-cycle start pulse to processing_core.
REQ-010 Port core_done, input, 1: one-cycle pulse from the core; result is valid.
REQ-011 Port r_addr, output, $clog2(DEPTH): PISO read address.
REQ-012 Port byte_sel, output, 2: selects the byte sent to the UART transmitter, LSB first.
REQ-013 Port tx_start, output, 1: one-cycle UART transmit request.
REQ-014 Port tx_busy, input, 1: UART transmitter busy.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port seq_done, output, 1: one-cycle pulse after the last byte has been sent.
REQ-017 Port timeout_err, output, 1: sticky; set on core timeout, cleared by the next accepted cmd_ready.
REQ-018 Port cmd_drop, output, 1: one-cycle pulse when cmd_ready arrives while busy=1.

Function
REQ-019 The FSM SHALL have states IDLE, START, WAIT_CORE, LOAD, SEND, WAIT_TX, NEXT, DONE.
REQ-020 IDLE -> START on cmd_ready; out_mode SHALL be latched into mode_q on the same cycle.
REQ-021 START SHALL assert core_start for exactly one cycle, clear the timeout counter and go to WAIT_CORE.
REQ-022 WAIT_CORE -> LOAD on core_done, with r_addr=0 and byte_sel=0.
REQ-023 WAIT_CORE -> IDLE when the counter reaches TIMEOUT_CYCLES-1 without core_done; timeout_err is set and no bytes are sent.
REQ-024 If core_done and the timeout expiry coincide, core_done SHALL win.
REQ-025 LOAD SHALL last exactly one cycle to cover the PISO read latency, then go to SEND.
REQ-026 SEND SHALL wait until tx_busy=0, assert tx_start for one cycle, then go to WAIT_TX.
REQ-027 WAIT_TX SHALL ignore tx_busy on its first cycle, then go to NEXT once tx_busy=0.
REQ-028 NEXT SHALL update the counters:
- if byte_sel < bytes-1: increment byte_sel, go to SEND.
- else if vector mode and r_addr < DEPTH-1: byte_sel=0, r_addr+1, go to LOAD.
- else: go to DONE.
REQ-029 bytes SHALL be SCAL_BYTES when mode_q=1 and VEC_BYTES when mode_q=0.
REQ-030 In scalar mode r_addr SHALL stay 0 and exactly SCAL_BYTES tx_start pulses SHALL occur.
REQ-031 In vector mode exactly DEPTH*VEC_BYTES tx_start pulses SHALL occur. r_addr SHALL never wrap past DEPTH-1.
REQ-032 DONE SHALL pulse seq_done for one cycle, then go to IDLE.
REQ-033 cmd_ready in any non-IDLE state SHALL be ignored and SHALL pulse cmd_drop.
REQ-034 An accepted cmd_ready SHALL clear timeout_err.
REQ-035 core_done in any state other than WAIT_CORE SHALL be ignored.
REQ-036 From cmd_ready to core_start SHALL be 1 cycle. From core_done to the first tx_start SHALL be 2 cycles, given tx_busy=0.

Reset
REQ-037 While rst_n=0 the state SHALL be IDLE, and core_start, tx_start, seq_done, cmd_drop, busy and timeout_err SHALL be 0.
REQ-038 While rst_n=0, r_addr=0, byte_sel=0, mode_q=0 and the timeout counter SHALL be 0.
REQ-039 Reset asserted mid-sequence SHALL abort immediately with no further tx_start. Release is synchronised and the block resumes in IDLE.

Structure
REQ-040 The shared package vc_pkg SHALL hold the seq_state_t enum, VEC_BYTES/SCAL_BYTES defaults and the SCALAR_W width constant.
REQ-041 The timeout counter SHALL be a separate sub-module, timeout_counter, with clear, enable and expired.
REQ-042 All outputs SHALL be registered. There SHALL be no combinational path from any input to any output.

Verification
REQ-043 Scalar op: cmd_ready with out_mode=1, core_done 10 cycles later, UART model busy 8 cycles per byte -> 4 tx_start pulses, byte_sel 0,1,2,3, r_addr=0, then one seq_done.
REQ-044 Vector op, DEPTH=8: cmd_ready with out_mode=0, then core_done -> 16 tx_start pulses, r_addr 0..7 with byte_sel 0,1 per address, seq_done, and r_addr never reaches 8.
REQ-045 Timeout, TIMEOUT_CYCLES=100: core_done withheld -> IDLE at 100 cycles after core_start, timeout_err=1, no tx_start. The next cmd_ready clears timeout_err.
REQ-046 Busy overlap: cmd_ready while in WAIT_TX -> one cmd_drop pulse and no second core_start; the sequence completes normally.
REQ-047 Backpressure: tx_busy held 1 for 50 cycles entering SEND -> tx_start delayed until tx_busy falls, and the byte count is unchanged.
REQ-048 Reset mid-vector: rst_n low at r_addr=3 -> all outputs at reset values within the same cycle. After release, a fresh scalar op completes correctly.
